// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one 8-bit flag-generating adder among NREQ requesters.
// Optional statistics counters (op_cnt, carry_cnt) are built when ADDER_ARB_STATS_EN is defined.
module adder_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   a_in,
    input  logic [8*NREQ-1:0]   b_in,
    output logic [NREQ-1:0]     gnt,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [IDW-1:0]      res_id,
    output logic [7:0]          res_sum,
    output logic [4:0]          res_flags
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [15:0]         op_cnt,
    output logic [15:0]         carry_cnt
`endif
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] win;
    logic [IDW:0]   cand;
    logic           found;
    logic           grant;
    logic           accept;
    logic [7:0]     a_sel;
    logic [7:0]     b_sel;
    logic [8:0]     sum9;
    logic [4:0]     nib;
    logic [4:0]     flags;

    // Scan req upward from ptr with wraparound; the first set bit wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found = 1'b1;
                win   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        a_sel    = a_in[{win, 3'b000} +: 8];
        b_sel    = b_in[{win, 3'b000} +: 8];
        sum9     = {1'b0, a_sel} + {1'b0, b_sel};
        nib      = {1'b0, a_sel[3:0]} + {1'b0, b_sel[3:0]};
        flags[4] = sum9[8];
        flags[3] = ~sum9[0];
        flags[2] = nib[4];
        flags[1] = ^sum9[7:0];
        flags[0] = (sum9[7:0] == 8'h00);
        ptr_next = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant      = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (res_valid && res_ready) begin
                    accept     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Result register is only written on a grant, so it stays frozen throughout HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_sum   <= 8'h00;
            res_flags <= 5'b00000;
            ptr       <= '0;
        end else begin
            gnt <= '0;
            if (grant) begin
                gnt[win]  <= 1'b1;
                res_valid <= 1'b1;
                res_id    <= win;
                res_sum   <= sum9[7:0];
                res_flags <= flags;
                ptr       <= ptr_next;
            end else if (accept) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef ADDER_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt    <= 16'h0000;
            carry_cnt <= 16'h0000;
        end else if (accept) begin
            op_cnt <= op_cnt + 16'h0001;
            if (res_flags[4]) begin
                carry_cnt <= carry_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule
